// File: rtl/cxd2545_subq_reader.sv
// Host-side CXD2545 SUBQ reader: on each SCOR edge it clocks CRCF plus an 80-bit Q frame out of SQSO.
// Optional BCD sanity check on ADR=1 frames is built when CXD2545_SUBQ_BCD_CHECK_EN is defined.
module cxd2545_subq_reader #(
    parameter int SQCK_HALF = 25,
    parameter int SETUP_CYC = 50,
    parameter int NBITS     = 80
) (
    input  logic             sys_clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             scor,
    input  logic             sqso,
    output logic             sqck,
    output logic             busy,
    output logic             subq_valid,
    output logic [NBITS-1:0] subq_data,
    output logic             crcf,
    output logic [7:0]       overrun_cnt,
    output logic             bcd_err
);

    localparam int DMAX = (SETUP_CYC > SQCK_HALF) ? SETUP_CYC : SQCK_HALF;
    localparam int CW   = $clog2(DMAX + 1);
    localparam int BW   = $clog2(NBITS + 1);

    typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, DONE} state_t;

    state_t           state;
    logic [2:0]       scor_sync;
    logic [2:0]       sqso_sync;
    logic             scor_prev;
    logic [CW-1:0]    dcnt;
    logic [BW-1:0]    bit_cnt;
    logic [NBITS-1:0] shift_reg;
    logic             crcf_shadow;

    logic          scor_edge;
    logic          sqso_s;
    logic [BW-1:0] bit_next;

    assign scor_edge = scor_sync[2] & ~scor_prev;
    assign sqso_s    = sqso_sync[2];
    assign bit_next  = bit_cnt + 1'b1;

`ifdef CXD2545_SUBQ_BCD_CHECK_EN
    // One flag per Q byte; byte 0 (CTRL/ADR) is never checked, byte 1 also accepts the 0xAA lead-out marker.
    logic [9:0] byte_bad;
    logic       bcd_bad;

    assign byte_bad[0] = 1'b0;
    genvar gi;
    generate
        for (gi = 1; gi < 10; gi++) begin : g_bcd
            logic [7:0] b;
            logic       nib_bad;
            assign b       = shift_reg[8*gi +: 8];
            assign nib_bad = (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
            if (gi == 1) begin : g_track
                assign byte_bad[gi] = nib_bad && (b != 8'hAA);
            end else begin : g_other
                assign byte_bad[gi] = nib_bad;
            end
        end
    endgenerate
    assign bcd_bad = |byte_bad;
`else
    assign bcd_err = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            scor_sync   <= '0;
            sqso_sync   <= '0;
            scor_prev   <= 1'b0;
            dcnt        <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            crcf_shadow <= 1'b0;
            sqck        <= 1'b1;
            busy        <= 1'b0;
            subq_valid  <= 1'b0;
            subq_data   <= '0;
            crcf        <= 1'b0;
            overrun_cnt <= '0;
`ifdef CXD2545_SUBQ_BCD_CHECK_EN
            bcd_err     <= 1'b0;
`endif
        end else begin
            scor_sync  <= {scor_sync[1:0], scor};
            sqso_sync  <= {sqso_sync[1:0], sqso};
            scor_prev  <= scor_sync[2];
            subq_valid <= 1'b0;

            // Any armed edge outside IDLE (including the DONE cycle) is an overrun, never a new read.
            if (scor_edge && enable && state != IDLE && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'd1;

            case (state)
                IDLE: begin
                    if (scor_edge && enable) begin
                        state   <= SETUP;
                        dcnt    <= CW'(SETUP_CYC - 1);
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                SETUP: begin
                    if (dcnt == '0) begin
                        crcf_shadow <= sqso_s;
                        state       <= LOW;
                        sqck        <= 1'b0;
                        dcnt        <= CW'(SQCK_HALF - 1);
                    end else begin
                        dcnt <= dcnt - 1'b1;
                    end
                end
                LOW: begin
                    if (dcnt == '0) begin
                        state <= HIGH;
                        sqck  <= 1'b1;
                        dcnt  <= CW'(SQCK_HALF - 1);
                    end else begin
                        dcnt <= dcnt - 1'b1;
                    end
                end
                HIGH: begin
                    if (dcnt == '0) begin
                        shift_reg <= {sqso_s, shift_reg[NBITS-1:1]};
                        bit_cnt   <= bit_next;
                        if (bit_next == BW'(NBITS)) begin
                            state <= DONE;
                        end else begin
                            state <= LOW;
                            sqck  <= 1'b0;
                            dcnt  <= CW'(SQCK_HALF - 1);
                        end
                    end else begin
                        dcnt <= dcnt - 1'b1;
                    end
                end
                DONE: begin
                    subq_data  <= shift_reg;
                    crcf       <= crcf_shadow;
                    subq_valid <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
`ifdef CXD2545_SUBQ_BCD_CHECK_EN
                    bcd_err    <= (shift_reg[3:0] == 4'd1) && bcd_bad;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
